// File: rtl/fanout_scheduler.sv
// Spike fan-out sequencer: walks a CSR row_ptr/column table per spike and
// streams destination neuron addresses over valid/ready, one per cycle.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   spike_valid/spike_ready/spike_src incoming spike handshake
//   dest_valid/dest_ready            outgoing destination handshake
//   dest_addr, dest_src, dest_last   destination word, burst source, last flag
//   done                             1-cycle pulse at burst end (incl. empty)
//   cfg_we/cfg_sel/cfg_addr/cfg_data CSR table write port (sel 0=row_ptr)
//   cfg_err                          1-cycle pulse when a write is dropped
module fanout_scheduler #(
    parameter int NUM_BITS_ADDR = 12,
    parameter int NEURONS       = 1024,
    parameter int MAX_CONN      = 5120,
    parameter int PTR_BITS      = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spike_valid,
    output logic                     spike_ready,
    input  logic [NUM_BITS_ADDR-1:0] spike_src,
    output logic                     dest_valid,
    input  logic                     dest_ready,
    output logic [NUM_BITS_ADDR-1:0] dest_addr,
    output logic [NUM_BITS_ADDR-1:0] dest_src,
    output logic                     dest_last,
    output logic                     done,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [PTR_BITS-1:0]      cfg_addr,
    input  logic [PTR_BITS-1:0]      cfg_data,
    output logic                     cfg_err
);

    localparam int RP_AW = $clog2(NEURONS + 1);
    localparam int CA_W  = $clog2(MAX_CONN);
    localparam int PW1   = PTR_BITS + 1;
    localparam int AW1   = NUM_BITS_ADDR + 1;

    localparam logic [PW1-1:0] ROW_LIM = PW1'(NEURONS);
    localparam logic [PW1-1:0] COL_LIM = PW1'(MAX_CONN);
    localparam logic [AW1-1:0] SRC_LIM = AW1'(NEURONS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT
    } state_t;

    state_t                   state_q;
    logic [NUM_BITS_ADDR-1:0] src_q;
    logic [PTR_BITS-1:0]      ptr_q;
    logic [PTR_BITS-1:0]      end_q;
    logic                     dest_valid_q;
    logic                     dest_last_q;
    logic                     done_q;
    logic                     cfg_err_q;

    logic [PTR_BITS-1:0]      rp_mem  [0:NEURONS];
    logic [NUM_BITS_ADDR-1:0] col_mem [0:MAX_CONN-1];
    logic [PTR_BITS-1:0]      rp_lo_q;
    logic [PTR_BITS-1:0]      rp_hi_q;
    logic [NUM_BITS_ADDR-1:0] col_q;

    logic                     accept;
    logic                     hs;
    logic                     src_ok;
    logic                     cfg_in_range;
    logic                     cfg_ok;
    logic                     rp_we;
    logic                     col_we;
    logic                     col_re;
    logic                     col_ok;
    logic [RP_AW-1:0]         rp_idx;
    logic [RP_AW-1:0]         rp_idx_hi;
    logic [PTR_BITS-1:0]      col_raddr;
    logic [PW1-1:0]           ptr_nx;
    logic                     empty_row;
    logic                     first_last;
    logic                     next_last;

    assign spike_ready = (state_q == S_IDLE);
    assign accept      = spike_valid && spike_ready;
    assign hs          = dest_valid_q && dest_ready;

    // Sources beyond the table read as an empty row instead of indexing
    // past the end of row_ptr.
    assign src_ok    = {1'b0, spike_src} < SRC_LIM;
    assign rp_idx    = spike_src[RP_AW-1:0];
    assign rp_idx_hi = rp_idx + RP_AW'(1);

    assign cfg_in_range = cfg_sel ? ({1'b0, cfg_addr} <  COL_LIM)
                                  : ({1'b0, cfg_addr} <= ROW_LIM);
    assign cfg_ok  = cfg_we && spike_ready && !spike_valid && cfg_in_range;
    assign rp_we   = cfg_ok && !cfg_sel;
    assign col_we  = cfg_ok && cfg_sel;

    // Pointer arithmetic is one bit wider so ptr+1 == end never wraps.
    assign ptr_nx     = {1'b0, ptr_q} + PW1'(1);
    assign empty_row  = rp_lo_q >= rp_hi_q;
    assign first_last = ({1'b0, rp_lo_q} + PW1'(1)) == {1'b0, rp_hi_q};
    assign next_last  = (ptr_nx + PW1'(1)) == {1'b0, end_q};

    // Column prefetch: first entry on leaving FETCH, next entry on each
    // non-final handshake so a word is ready every cycle.
    always_comb begin
        col_re    = 1'b0;
        col_raddr = rp_lo_q;
        if (state_q == S_FETCH && !empty_row) begin
            col_re    = 1'b1;
            col_raddr = rp_lo_q;
        end else if (state_q == S_EMIT && hs && !dest_last_q) begin
            col_re    = 1'b1;
            col_raddr = ptr_nx[PTR_BITS-1:0];
        end
    end

    assign col_ok = {1'b0, col_raddr} < COL_LIM;

    always_ff @(posedge clk) begin
        if (rp_we) begin
            rp_mem[cfg_addr[RP_AW-1:0]] <= cfg_data;
        end
        if (col_we) begin
            col_mem[cfg_addr[CA_W-1:0]] <= cfg_data[NUM_BITS_ADDR-1:0];
        end
        if (accept) begin
            if (src_ok) begin
                rp_lo_q <= rp_mem[rp_idx];
                rp_hi_q <= rp_mem[rp_idx_hi];
            end else begin
                rp_lo_q <= '0;
                rp_hi_q <= '0;
            end
        end
    end

    // Column read register doubles as dest_addr, so it carries the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
        end else if (col_re) begin
            col_q <= col_ok ? col_mem[col_raddr[CA_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            ptr_q        <= '0;
            end_q        <= '0;
            dest_valid_q <= 1'b0;
            dest_last_q  <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= cfg_we && !cfg_ok;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        src_q   <= spike_src;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ptr_q <= rp_lo_q;
                    end_q <= rp_hi_q;
                    if (empty_row) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        dest_valid_q <= 1'b1;
                        dest_last_q  <= first_last;
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (hs) begin
                        if (dest_last_q) begin
                            dest_valid_q <= 1'b0;
                            dest_last_q  <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            ptr_q       <= ptr_nx[PTR_BITS-1:0];
                            dest_last_q <= next_last;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dest_valid = dest_valid_q;
    assign dest_addr  = col_q;
    assign dest_src   = src_q;
    assign dest_last  = dest_last_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fanout_scheduler.sv
// Bench for fanout_scheduler: queue-based reference model compared every
// cycle, plus directed literal checks for each scenario.
module tb_fanout_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        spike_valid = 1'b0;
    logic        spike_ready;
    logic [11:0] spike_src = '0;
    logic        dest_valid;
    logic        dest_ready = 1'b1;
    logic [11:0] dest_addr;
    logic [11:0] dest_src;
    logic        dest_last;
    logic        done;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [12:0] cfg_addr = '0;
    logic [12:0] cfg_data = '0;
    logic        cfg_err;

    fanout_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_src(spike_src),
        .dest_valid(dest_valid), .dest_ready(dest_ready),
        .dest_addr(dest_addr), .dest_src(dest_src), .dest_last(dest_last),
        .done(done),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: tables plus a queue of pending destinations.
    int rp_m [0:1024];
    int col_m [0:5119];
    int q [$];
    bit mbusy = 0;
    bit mwait = 0;
    bit mdone = 0;
    bit merr = 0;
    int msrc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy = 0; mwait = 0; mdone = 0; merr = 0; msrc = 0;
            q.delete();
        end else begin
            mdone = 0;
            merr = 0;
            if (cfg_we) begin
                if (!mbusy && !spike_valid &&
                    (cfg_sel ? (cfg_addr < 5120) : (cfg_addr <= 1024))) begin
                    if (cfg_sel) col_m[cfg_addr] = int'(cfg_data) & 'hFFF;
                    else rp_m[cfg_addr] = int'(cfg_data);
                end else begin
                    merr = 1;
                end
            end
            if (!mbusy) begin
                if (spike_valid) begin
                    msrc = int'(spike_src);
                    for (int k = rp_m[msrc]; k < rp_m[msrc + 1]; k++)
                        q.push_back(col_m[k]);
                    mbusy = 1;
                    mwait = 1;
                end
            end else if (mwait) begin
                mwait = 0;
                if (q.size() == 0) begin mdone = 1; mbusy = 0; end
            end else if (dest_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) begin mdone = 1; mbusy = 0; end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = mbusy && !mwait && q.size() > 0;
        chk("spike_ready", spike_ready, !mbusy);
        chk("dest_valid", dest_valid, ev);
        chk("done", done, mdone);
        chk("cfg_err", cfg_err, merr);
        if (ev) begin
            chk("dest_addr", dest_addr, q[0]);
            chk("dest_last", dest_last, q.size() == 1);
            chk("dest_src", dest_src, msrc);
        end
    end

    // Event log used by the directed checks.
    int cyc = 0;
    int got_a [$];
    int got_l [$];
    int got_c [$];
    int first_v = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int err_cnt = 0;
    int acc_cyc = 0;
    int d_before = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dest_valid && dest_ready) begin
            got_a.push_back(int'(dest_addr));
            got_l.push_back(int'(dest_last));
            got_c.push_back(cyc);
        end
        if (dest_valid && first_v < 0) first_v = cyc;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (cfg_err) err_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input bit sel, input int a, input int d);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_addr = 13'(a);
        cfg_data = 13'(d);
        step();
        cfg_we = 1'b0;
        step();
    endtask

    task automatic clear_log();
        got_a.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic send_spike(input int s);
        bit ok;
        ok = 0;
        d_before = done_cnt;
        first_v = -1;
        done_cyc = -1;
        spike_valid = 1'b1;
        spike_src = 12'(s);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (spike_ready) begin
                ok = 1;
                acc_cyc = cyc;
            end
        end
        step();
        spike_valid = 1'b0;
        chk("spike accept within bound", ok, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && done_cnt == d_before; i++) step();
        chk("done within bound", done_cnt > d_before, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !dest_valid; i++) step();
        chk("dest_valid within bound", dest_valid, 1);
    endtask

    initial begin
        int e0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("rst spike_ready", spike_ready, 1);
        chk("rst dest_valid", dest_valid, 0);
        chk("rst dest_last", dest_last, 0);
        chk("rst done", done, 0);
        chk("rst cfg_err", cfg_err, 0);
        chk("rst dest_addr", dest_addr, 0);
        chk("rst dest_src", dest_src, 0);
        rst_n = 1'b1;
        step();

        cfg_wr(0, 0, 0);
        cfg_wr(0, 1, 3);
        cfg_wr(0, 2, 5);
        cfg_wr(0, 6, 14);
        cfg_wr(0, 7, 14);
        cfg_wr(0, 1023, 5119);
        cfg_wr(0, 1024, 5120);
        cfg_wr(1, 0, 3);
        cfg_wr(1, 1, 5);
        cfg_wr(1, 2, 7);
        cfg_wr(1, 3, 4);
        cfg_wr(1, 4, 6);
        cfg_wr(1, 5119, 'hABC);
        chk("load no err", err_cnt, 0);

        cfg_wr(0, 1025, 7);
        cfg_wr(1, 5120, 7);
        chk("out of range err", err_cnt, 2);

        // Three destinations back to back.
        clear_log();
        send_spike(0);
        wait_done();
        chk("t1 count", got_a.size(), 3);
        chk("t1 a0", got_a[0], 3);
        chk("t1 a1", got_a[1], 5);
        chk("t1 a2", got_a[2], 7);
        chk("t1 last0", got_l[0], 0);
        chk("t1 last1", got_l[1], 0);
        chk("t1 last2", got_l[2], 1);
        chk("t1 latency", first_v - acc_cyc, 2);
        chk("t1 gap01", got_c[1] - got_c[0], 1);
        chk("t1 gap12", got_c[2] - got_c[1], 1);
        chk("t1 done after last", done_cyc - got_c[2], 1);

        // Empty row.
        clear_log();
        send_spike(6);
        wait_done();
        chk("t2 no valid", first_v, -1);
        chk("t2 count", got_a.size(), 0);
        chk("t2 done timing", done_cyc - acc_cyc, 2);
        chk("t2 ready back", spike_ready, 1);

        // Backpressure, with a config write attempted mid-burst.
        clear_log();
        dest_ready = 1'b0;
        send_spike(1);
        wait_valid();
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            chk("t3 hold valid", dest_valid, 1);
            chk("t3 hold addr", dest_addr, 4);
            chk("t3 hold last", dest_last, 0);
            if (i == 0) begin
                cfg_we = 1'b1; cfg_sel = 1'b1;
                cfg_addr = 13'd3; cfg_data = 13'd9;
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        dest_ready = 1'b1;
        wait_done();
        chk("t3 count", got_a.size(), 2);
        chk("t3 a0", got_a[0], 4);
        chk("t3 a1", got_a[1], 6);
        chk("t3 last1", got_l[1], 1);
        chk("t4 emit write err", err_cnt - e0, 1);

        clear_log();
        send_spike(1);
        wait_done();
        chk("t4 count", got_a.size(), 2);
        chk("t4 a0 unchanged", got_a[0], 4);
        chk("t4 a1", got_a[1], 6);

        // Last neuron, last column slot.
        clear_log();
        send_spike(1023);
        wait_done();
        chk("t5 count", got_a.size(), 1);
        chk("t5 a0", got_a[0], 'hABC);
        chk("t5 last", got_l[0], 1);

        // Write in the same cycle as a spike accept is dropped.
        clear_log();
        e0 = err_cnt;
        cfg_we = 1'b1; cfg_sel = 1'b1;
        cfg_addr = 13'd0; cfg_data = 13'd77;
        send_spike(0);
        cfg_we = 1'b0;
        wait_done();
        chk("accept write err", err_cnt - e0, 1);
        chk("accept write a0", got_a[0], 3);

        // Reset in the middle of a burst.
        send_spike(0);
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("t6 valid drop", dest_valid, 0);
        chk("t6 spike_ready", spike_ready, 1);
        chk("t6 done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        clear_log();
        send_spike(0);
        wait_done();
        chk("t6 count", got_a.size(), 3);
        chk("t6 a0", got_a[0], 3);
        chk("t6 a1", got_a[1], 5);
        chk("t6 a2", got_a[2], 7);
        chk("t6 last2", got_l[2], 1);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
